// File: rtl/tcpc_reset_tx_ctrl.sv
// Hard Reset / Cable Reset transmit sequencer for the TCPC reset path.
// Decodes TRANSMIT writes, clears RX, drives the PHY request with timeout/retry and reports via ALERT.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a TRANSMIT write of Hard/Cable Reset
// CLR_RX   | one-cycle pulse clearing RECEIVE_DETECT / RECEIVE_BYTE_COUNT
// REQ      | request low for one cycle, attempt timer loaded
// WAIT_ACK | request high, waiting for PHY_ACK, abort or timeout
// DONE     | one-cycle ALERT set-pulse and TRANSMIT clear
module tcpc_reset_tx_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRIES    = 2,
   parameter int CNT_W          = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  iTRANSMIT,
   input  logic        iTRANSMIT_WR,
   input  logic        PHY_ACK,
   input  logic        PHY_Stop_Attempting_Reset,
   output logic        oPHY_REQ,
   output logic [1:0]  oPHY_TYPE,
   output logic        oCLR_RX,
   output logic [15:0] oALERT_SET,
   output logic        oTRANSMIT_CLR,
   output logic        oBUSY
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CLR_RX   = 3'd1,
      ST_REQ      = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam logic [2:0] CODE_HARD  = 3'b101;
   localparam logic [2:0] CODE_CABLE = 3'b110;

   localparam logic [1:0] TYPE_HARD  = 2'b01;
   localparam logic [1:0] TYPE_CABLE = 2'b10;

   localparam logic [1:0] RES_NONE    = 2'd0;
   localparam logic [1:0] RES_SUCCESS = 2'd1;
   localparam logic [1:0] RES_DISCARD = 2'd2;
   localparam logic [1:0] RES_FAIL    = 2'd3;

   localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(1);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] timer;
   logic [3:0]       retries;
   logic [1:0]       reset_type;
   logic [1:0]       result;

   logic [2:0] tx_code;
   logic       start_req;
   logic       timer_last;
   logic       retry_left;
   logic       unused_transmit_hi;

   assign tx_code    = iTRANSMIT[2:0];
   assign start_req  = iTRANSMIT_WR && ((tx_code == CODE_HARD) || (tx_code == CODE_CABLE));
   assign timer_last = (timer == TIMER_LAST);
   assign retry_left = (retries < RETRY_MAX);

   // Upper TRANSMIT bits belong to the message TX path.
   assign unused_transmit_hi = ^iTRANSMIT[7:3];

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_req) begin
               state_nxt = ST_CLR_RX;
            end
         end
         ST_CLR_RX: begin
            state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (PHY_Stop_Attempting_Reset) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (PHY_Stop_Attempting_Reset || PHY_ACK) begin
               state_nxt = ST_DONE;
            end else if (timer_last) begin
               state_nxt = retry_left ? ST_REQ : ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Timer, retry count, captured type and result track the FSM decisions above.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         timer      <= '0;
         retries    <= '0;
         reset_type <= 2'b00;
         result     <= RES_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               retries <= '0;
               result  <= RES_NONE;
               if (start_req) begin
                  reset_type <= (tx_code == CODE_HARD) ? TYPE_HARD : TYPE_CABLE;
               end
            end
            ST_REQ: begin
               timer <= TIMER_LOAD;
               if (PHY_Stop_Attempting_Reset) begin
                  result <= RES_DISCARD;
               end
            end
            ST_WAIT_ACK: begin
               timer <= timer - TIMER_LAST;
               if (PHY_Stop_Attempting_Reset) begin
                  result <= RES_DISCARD;
               end else if (PHY_ACK) begin
                  result <= RES_SUCCESS;
               end else if (timer_last) begin
                  if (retry_left) begin
                     retries <= retries + 4'd1;
                  end else begin
                     result <= RES_FAIL;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      oPHY_REQ      = 1'b0;
      oPHY_TYPE     = 2'b00;
      oCLR_RX       = 1'b0;
      oALERT_SET    = 16'h0000;
      oTRANSMIT_CLR = 1'b0;
      oBUSY         = 1'b0;
      case (state)
         ST_IDLE: begin
         end
         ST_CLR_RX: begin
            oBUSY     = 1'b1;
            oPHY_TYPE = reset_type;
            oCLR_RX   = 1'b1;
         end
         ST_REQ: begin
            oBUSY     = 1'b1;
            oPHY_TYPE = reset_type;
         end
         ST_WAIT_ACK: begin
            oBUSY     = 1'b1;
            oPHY_TYPE = reset_type;
            oPHY_REQ  = 1'b1;
         end
         ST_DONE: begin
            oBUSY         = 1'b1;
            oPHY_TYPE     = reset_type;
            oTRANSMIT_CLR = 1'b1;
            case (result)
               RES_SUCCESS: oALERT_SET = 16'h0040;
               RES_DISCARD: oALERT_SET = 16'h0020;
               RES_FAIL:    oALERT_SET = 16'h0010;
               default:     oALERT_SET = 16'h0000;
            endcase
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_tcpc_reset_tx_ctrl.sv
// Directed bench for tcpc_reset_tx_ctrl: success, timeout/retry, abort, ignored writes and reset.
module tb_tcpc_reset_tx_ctrl;

   logic        CLK;
   logic        reset;
   logic [7:0]  iTRANSMIT;
   logic        iTRANSMIT_WR;
   logic        PHY_ACK;
   logic        PHY_Stop_Attempting_Reset;
   logic        oPHY_REQ;
   logic [1:0]  oPHY_TYPE;
   logic        oCLR_RX;
   logic [15:0] oALERT_SET;
   logic        oTRANSMIT_CLR;
   logic        oBUSY;

   int n_cmp = 0;
   int n_err = 0;

   tcpc_reset_tx_ctrl #(
      .TIMEOUT_CYCLES(16),
      .MAX_RETRIES   (2),
      .CNT_W         (8)
   ) dut (
      .CLK                      (CLK),
      .reset                    (reset),
      .iTRANSMIT                (iTRANSMIT),
      .iTRANSMIT_WR             (iTRANSMIT_WR),
      .PHY_ACK                  (PHY_ACK),
      .PHY_Stop_Attempting_Reset(PHY_Stop_Attempting_Reset),
      .oPHY_REQ                 (oPHY_REQ),
      .oPHY_TYPE                (oPHY_TYPE),
      .oCLR_RX                  (oCLR_RX),
      .oALERT_SET               (oALERT_SET),
      .oTRANSMIT_CLR            (oTRANSMIT_CLR),
      .oBUSY                    (oBUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_success(input string tag);
      iTRANSMIT    = 8'h05;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      chk({tag, "_clr_rx"}, 32'(oCLR_RX), 32'd1);
      chk({tag, "_type"}, 32'(oPHY_TYPE), 32'd1);
      chk({tag, "_req_clr"}, 32'(oPHY_REQ), 32'd0);
      step();
      chk({tag, "_req_gap"}, 32'(oPHY_REQ), 32'd0);
      chk({tag, "_clr_once"}, 32'(oCLR_RX), 32'd0);
      step();
      chk({tag, "_req_w1"}, 32'(oPHY_REQ), 32'd1);
      step();
      chk({tag, "_req_w2"}, 32'(oPHY_REQ), 32'd1);
      PHY_ACK = 1'b1;
      step();
      PHY_ACK = 1'b0;
      chk({tag, "_alert"}, 32'(oALERT_SET), 32'h0040);
      chk({tag, "_tx_clr"}, 32'(oTRANSMIT_CLR), 32'd1);
      chk({tag, "_req_done"}, 32'(oPHY_REQ), 32'd0);
      step();
      chk({tag, "_alert_end"}, 32'(oALERT_SET), 32'h0000);
      chk({tag, "_busy_end"}, 32'(oBUSY), 32'd0);
      chk({tag, "_type_end"}, 32'(oPHY_TYPE), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hi;
      int win;
      int run;
      int gap;
      int type_bad;
      int cyc;
      int alerts;
      int busy_cyc;
      logic prev;

      reset                     = 1'b0;
      iTRANSMIT                 = 8'h00;
      iTRANSMIT_WR              = 1'b0;
      PHY_ACK                   = 1'b0;
      PHY_Stop_Attempting_Reset = 1'b0;
      #1;
      chk("rst_busy", 32'(oBUSY), 32'd0);
      chk("rst_req", 32'(oPHY_REQ), 32'd0);
      chk("rst_alert", 32'(oALERT_SET), 32'h0000);
      chk("rst_type", 32'(oPHY_TYPE), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // ACK while idle does nothing
      PHY_ACK = 1'b1;
      step();
      PHY_ACK = 1'b0;
      chk("idle_ack_busy", 32'(oBUSY), 32'd0);
      chk("idle_ack_alert", 32'(oALERT_SET), 32'h0000);

      // 1: hard reset, ACK on second WAIT_ACK cycle
      run_success("t1");

      // 2: cable reset, no ACK: three 16-cycle windows, 1-cycle gaps, FAILED
      iTRANSMIT    = 8'h06;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      hi = 0; win = 0; run = 0; gap = 0; type_bad = 0; cyc = 0; prev = 1'b0;
      while (cyc < 200 && oALERT_SET == 16'h0000) begin
         if (oPHY_TYPE !== 2'b10) type_bad++;
         if (oPHY_REQ) begin
            hi++;
            if (!prev) win++;
            run++;
         end else begin
            if (prev) chk("t2_win_len", 32'(run), 32'd16);
            run = 0;
            if (win > 0) gap++;
         end
         prev = oPHY_REQ;
         cyc++;
         step();
      end
      if (prev) chk("t2_win_len_last", 32'(run), 32'd16);
      chk("t2_alert", 32'(oALERT_SET), 32'h0010);
      chk("t2_tx_clr", 32'(oTRANSMIT_CLR), 32'd1);
      chk("t2_type_done", 32'(oPHY_TYPE), 32'd2);
      chk("t2_type_bad", 32'(type_bad), 32'd0);
      chk("t2_req_cycles", 32'(hi), 32'd48);
      chk("t2_windows", 32'(win), 32'd3);
      chk("t2_gaps", 32'(gap), 32'd2);
      chk("t2_total_cycles", 32'(cyc), 32'd52);
      step();
      chk("t2_idle", 32'(oBUSY), 32'd0);

      // 3: stop and ACK together -> DISCARDED, no retry
      iTRANSMIT    = 8'h05;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      step();
      step();
      PHY_ACK                   = 1'b1;
      PHY_Stop_Attempting_Reset = 1'b1;
      step();
      PHY_ACK                   = 1'b0;
      PHY_Stop_Attempting_Reset = 1'b0;
      chk("t3_alert", 32'(oALERT_SET), 32'h0020);
      step();
      chk("t3_busy", 32'(oBUSY), 32'd0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         if (oPHY_REQ) hi++;
         step();
      end
      chk("t3_no_retry", 32'(hi), 32'd0);

      // 4: ACK on final cycle of first window
      iTRANSMIT    = 8'h05;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      step();
      step();
      hi = 0;
      for (int i = 0; i < 15; i++) begin
         if (oPHY_REQ) hi++;
         step();
      end
      if (oPHY_REQ) hi++;
      chk("t4_req_cycles", 32'(hi), 32'd16);
      PHY_ACK = 1'b1;
      step();
      PHY_ACK = 1'b0;
      chk("t4_alert", 32'(oALERT_SET), 32'h0040);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (oPHY_REQ) hi++;
      end
      chk("t4_no_second", 32'(hi), 32'd0);

      // 5: ignored codes, and writes while busy
      iTRANSMIT    = 8'h00;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      chk("t5_code0_busy", 32'(oBUSY), 32'd0);
      chk("t5_code0_clr", 32'(oCLR_RX), 32'd0);
      iTRANSMIT    = 8'h07;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      chk("t5_code7_busy", 32'(oBUSY), 32'd0);
      chk("t5_code7_clr", 32'(oCLR_RX), 32'd0);
      iTRANSMIT    = 8'h05;
      iTRANSMIT_WR = 1'b1;
      step();
      step();
      step();
      iTRANSMIT_WR = 1'b0;
      PHY_ACK      = 1'b1;
      step();
      PHY_ACK      = 1'b0;
      iTRANSMIT_WR = 1'b1;
      alerts = 0; busy_cyc = 0;
      for (int i = 0; i < 30; i++) begin
         if (oALERT_SET != 16'h0000) alerts++;
         if (oBUSY && i > 0) busy_cyc++;
         step();
         iTRANSMIT_WR = 1'b0;
      end
      chk("t5_alert_count", 32'(alerts), 32'd1);
      chk("t5_no_requeue", 32'(busy_cyc), 32'd0);

      // 6: reset mid-WAIT_ACK, then normal operation
      iTRANSMIT    = 8'h05;
      iTRANSMIT_WR = 1'b1;
      step();
      iTRANSMIT_WR = 1'b0;
      step();
      step();
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("t6_req", 32'(oPHY_REQ), 32'd0);
      chk("t6_busy", 32'(oBUSY), 32'd0);
      chk("t6_type", 32'(oPHY_TYPE), 32'd0);
      chk("t6_alert", 32'(oALERT_SET), 32'h0000);
      chk("t6_tx_clr", 32'(oTRANSMIT_CLR), 32'd0);
      alerts = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (oALERT_SET != 16'h0000 || oBUSY) alerts++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (oALERT_SET != 16'h0000 || oBUSY) alerts++;
      end
      chk("t6_quiet", 32'(alerts), 32'd0);
      run_success("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
